// File: rtl/tdc_pkg.sv
// Shared types and default widths for the ADPLL TDC digital back-end.
package tdc_pkg;

  localparam int RIPPLE_W  = 7;
  localparam int PHASE_W   = 16;
  localparam int FRAC_W    = 4;
  localparam int WORD_W    = 12;
  localparam int CUR_W     = RIPPLE_W + FRAC_W;
  localparam int PRIME_CYC = 3;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } tdc_state_e;

endpackage

// File: rtl/tdc_therm_decode.sv
// Thermometer snapshot decoder: popcount of passed stages plus a flag for
// codes that are not LSB-aligned runs of ones.
module tdc_therm_decode #(
  parameter int PHASE_W = tdc_pkg::PHASE_W,
  parameter int ONES_W  = $clog2(PHASE_W + 1)
) (
  input  logic [PHASE_W-1:0] phase_i,
  output logic [ONES_W-1:0]  ones_o,
  output logic               err_o
);

  logic [PHASE_W:0] phase_ext;
  logic [PHASE_W:0] phase_inc;

  // NOTE: blocking accumulation is intended in combinational logic; the
  // default assignment first means every path drives ones_o, so no latch.
  always_comb begin
    ones_o = '0;
    for (int k = 0; k < PHASE_W; k++) begin
      ones_o = ones_o + ONES_W'(phase_i[k]);
    end
  end

  // A clean code 0..01..1 plus one is a single power of two with no overlap.
  assign phase_ext = {1'b0, phase_i};
  assign phase_inc = phase_ext + (PHASE_W + 1)'(1);
  assign err_o     = |(phase_ext & phase_inc);

endmodule

// File: rtl/tdc_digital.sv
// TDC digital back-end: samples ripple count and thermometer phase, decodes
// them to a fractional phase and accumulates an unwrapped variable phase.
module tdc_digital #(
  parameter int RIPPLE_W  = tdc_pkg::RIPPLE_W,
  parameter int PHASE_W   = tdc_pkg::PHASE_W,
  parameter int FRAC_W    = tdc_pkg::FRAC_W,
  parameter int WORD_W    = tdc_pkg::WORD_W,
  parameter int PRIME_CYC = tdc_pkg::PRIME_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pd,
  input  logic [RIPPLE_W-1:0] ripple_count,
  input  logic [PHASE_W-1:0]  phase,
  output logic [WORD_W-1:0]   tdc_word,
  output logic [WORD_W-1:0]   tdc_delta,
  output logic                tdc_valid,
  output logic                therm_err
);

  localparam int CUR_W  = RIPPLE_W + FRAC_W;
  localparam int ONES_W = $clog2(PHASE_W + 1);
  localparam int CNT_W  = $clog2(PRIME_CYC);

  // S1: raw analog samples
  logic [RIPPLE_W-1:0] ripple_q;
  logic [PHASE_W-1:0]  phase_q;

  // S2: decoded phase
  logic [ONES_W-1:0]   ones;
  logic                err_d;
  logic [CUR_W-1:0]    cur_d;
  logic [CUR_W-1:0]    cur_q;
  logic                err_q;

  // S3: control and outputs
  tdc_pkg::tdc_state_e state_q;
  logic [CNT_W-1:0]    prime_cnt_q;
  logic [CUR_W-1:0]    prev_cur_q;
  logic [WORD_W-1:0]   word_q;
  logic [WORD_W-1:0]   delta_q;
  logic                valid_q;
  logic                therm_err_q;

  logic [CUR_W-1:0]    delta_cur;
  logic [WORD_W-1:0]   delta_ext;
  logic                go;

  tdc_therm_decode #(
    .PHASE_W (PHASE_W),
    .ONES_W  (ONES_W)
  ) u_decode (
    .phase_i (phase_q),
    .ones_o  (ones),
    .err_o   (err_d)
  );

  // ones == PHASE_W carries naturally into the ripple field.
  assign cur_d = {ripple_q, {FRAC_W{1'b0}}} + CUR_W'(ones);

  // NOTE: the sample pipeline is reset along with the control state so that
  // nothing downstream ever sees an undefined sample after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ripple_q <= '0;
      phase_q  <= '0;
      cur_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ripple_q <= ripple_count;
      phase_q  <= phase;
      cur_q    <= cur_d;
      err_q    <= err_d;
    end
  end

  assign delta_cur = cur_q - prev_cur_q;
  assign delta_ext = WORD_W'(delta_cur);
  assign go        = en && !pd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= tdc_pkg::ST_OFF;
      prime_cnt_q <= '0;
      prev_cur_q  <= '0;
      word_q      <= '0;
      delta_q     <= '0;
      valid_q     <= 1'b0;
      therm_err_q <= 1'b0;
    end else begin
      case (state_q)
        tdc_pkg::ST_OFF: begin
          if (go) begin
            state_q     <= tdc_pkg::ST_PRIME;
            prime_cnt_q <= '0;
          end
        end
        tdc_pkg::ST_PRIME: begin
          if (!go) begin
            state_q <= tdc_pkg::ST_OFF;
          end else if (prime_cnt_q == CNT_W'(PRIME_CYC - 1)) begin
            state_q     <= tdc_pkg::ST_RUN;
            prev_cur_q  <= cur_q;
            word_q      <= WORD_W'(cur_q);
            delta_q     <= '0;
            therm_err_q <= err_q;
            valid_q     <= 1'b1;
          end else begin
            prime_cnt_q <= prime_cnt_q + CNT_W'(1);
          end
        end
        tdc_pkg::ST_RUN: begin
          if (!go) begin
            // Leave the last update on the outputs; re-entry re-primes.
            state_q <= tdc_pkg::ST_OFF;
            valid_q <= 1'b0;
          end else begin
            prev_cur_q  <= cur_q;
            delta_q     <= delta_ext;
            word_q      <= word_q + delta_ext;
            therm_err_q <= err_q;
          end
        end
        default: begin
          state_q <= tdc_pkg::ST_OFF;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tdc_word  = word_q;
  assign tdc_delta = delta_q;
  assign tdc_valid = valid_q;
  assign therm_err = therm_err_q;

endmodule
